// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider, one quotient bit per clock.
// Supports signed or unsigned operation per request, flags divide-by-zero,
// and uses valid/ready handshakes on both the request and result sides.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   rem_q, rem_d;     // partial remainder, always < divisor
    logic [WIDTH-1:0]   dvd_q, dvd_d;     // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0]   dsr_q, dsr_d;     // divisor magnitude
    logic [CW-1:0]      cnt_q, cnt_d;     // remaining steps
    logic               qneg_q, qneg_d;   // negate quotient at the end
    logic               rneg_q, rneg_d;   // negate remainder at the end
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rmd_q, rmd_d;
    logic               dbz_q, dbz_d;

    // Operand magnitudes; the most-negative value maps onto itself, which
    // is the correct unsigned magnitude in WIDTH bits.
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    // One restoring step on the current datapath registers.
    logic [WIDTH:0]     partial;
    logic               ge;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic [WIDTH-1:0]   q_final, r_final;

    // Operand sign handling and the single shift-subtract step.
    always_comb begin
        a_neg    = is_signed & a[WIDTH-1];
        b_neg    = is_signed & b[WIDTH-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        partial  = {rem_q, dvd_q[WIDTH-1]};
        ge       = (partial >= {1'b0, dsr_q});
        // Result of the subtraction is below the divisor, so it fits WIDTH bits.
        rem_step = ge ? WIDTH'(partial - {1'b0, dsr_q}) : partial[WIDTH-1:0];
        quo_step = {dvd_q[WIDTH-2:0], ge};
        q_final  = qneg_q ? -quo_step : quo_step;
        r_final  = rneg_q ? -rem_step : rem_step;
    end

    // Next-state and datapath control for the IDLE/BUSY/DONE machine.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (b == '0) begin
                        // No iteration needed: publish the fixed result directly.
                        state_d = DONE;
                        quo_d   = '1;
                        rmd_d   = a;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CW'(WIDTH);
                        rem_d   = '0;
                        dvd_d   = a_mag;
                        dsr_d   = b_mag;
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                    end
                end
            end
            BUSY: begin
                rem_d = rem_step;
                dvd_d = quo_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    // Last step: apply signs while loading the result registers.
                    state_d = DONE;
                    quo_d   = q_final;
                    rmd_d   = r_final;
                    dbz_d   = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
        end
    end

    // Handshake flags come straight from the state; results hold until the next one.
    always_comb begin
        in_ready    = (state_q == IDLE);
        out_valid   = (state_q == DONE);
        quotient    = quo_q;
        remainder   = rmd_q;
        div_by_zero = dbz_q;
    end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed vectors for 32-bit and 8-bit div_seq instances,
// plus hand-written backpressure and mid-operation reset sequences.
module tb_div_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic out_ready;

    logic        iv32, ir32, is32, ov32, dz32;
    logic [31:0] a32, b32, q32, r32;
    logic        iv8, ir8, is8, ov8, dz8;
    logic [7:0]  a8, b8, q8, r8;

    div_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(iv32), .in_ready(ir32),
        .a(a32), .b(b32), .is_signed(is32),
        .out_valid(ov32), .out_ready(out_ready),
        .quotient(q32), .remainder(r32), .div_by_zero(dz32)
    );

    div_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .is_signed(is8),
        .out_valid(ov8), .out_ready(out_ready),
        .quotient(q8), .remainder(r8), .div_by_zero(dz8)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        bit          w8;
        logic [31:0] a;
        logic [31:0] b;
        bit          s;
        logic [31:0] q;
        logic [31:0] r;
        bit          dz;
        int          lat;
    } vec_t;

    vec_t tbl[16];

    // Issue one request (inputs driven 1 time unit after an edge) and wait
    // for out_valid. lat counts rising edges after the acceptance edge; a
    // divide-by-zero result is already valid in the cycle following acceptance.
    task automatic run_op(input bit w8, input logic [31:0] a, input logic [31:0] b,
                          input bit s, output int lat, output logic [31:0] q,
                          output logic [31:0] r, output logic dz);
        if (w8) begin
            a8 = a[7:0]; b8 = b[7:0]; is8 = s; iv8 = 1'b1;
            check("in_ready before accept (w8)", {31'b0, ir8}, 32'd1);
        end else begin
            a32 = a; b32 = b; is32 = s; iv32 = 1'b1;
            check("in_ready before accept", {31'b0, ir32}, 32'd1);
        end
        @(posedge clk); #1;
        iv8  = 1'b0;
        iv32 = 1'b0;
        lat  = 0;
        while (((w8 ? ov8 : ov32) !== 1'b1) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 100) begin
            check("out_valid timeout", 32'd0, 32'd1);
        end
        q  = w8 ? {24'b0, q8} : q32;
        r  = w8 ? {24'b0, r8} : r32;
        dz = w8 ? dz8 : dz32;
    endtask

    initial begin
        int          lat;
        logic [31:0] q, r;
        logic        dz;

        tbl[0]  = '{"u 100/7",          0, 32'd100,        32'd7,          0, 32'd14,         32'd2,          0, 32};
        tbl[1]  = '{"s -7/2",           0, 32'hFFFFFFF9,   32'd2,          1, 32'hFFFFFFFD,   32'hFFFFFFFF,   0, 32};
        tbl[2]  = '{"s 7/-2",           0, 32'd7,          32'hFFFFFFFE,   1, 32'hFFFFFFFD,   32'd1,          0, 32};
        tbl[3]  = '{"s -7/-2",          0, 32'hFFFFFFF9,   32'hFFFFFFFE,   1, 32'd3,          32'hFFFFFFFF,   0, 32};
        tbl[4]  = '{"u 5/0",            0, 32'd5,          32'd0,          0, 32'hFFFFFFFF,   32'd5,          1, 0};
        tbl[5]  = '{"u 100/7 after dz", 0, 32'd100,        32'd7,          0, 32'd14,         32'd2,          0, 32};
        tbl[6]  = '{"s minneg/-1",      0, 32'h80000000,   32'hFFFFFFFF,   1, 32'h80000000,   32'd0,          0, 32};
        tbl[7]  = '{"u 0x8..0/0xF..F",  0, 32'h80000000,   32'hFFFFFFFF,   0, 32'd0,          32'h80000000,   0, 32};
        tbl[8]  = '{"u max/16",         0, 32'hFFFFFFFF,   32'd16,         0, 32'h0FFFFFFF,   32'h0000000F,   0, 32};
        tbl[9]  = '{"u 3/5",            0, 32'd3,          32'd5,          0, 32'd0,          32'd3,          0, 32};
        tbl[10] = '{"s -5/0",           0, 32'hFFFFFFFB,   32'd0,          1, 32'hFFFFFFFF,   32'hFFFFFFFB,   1, 0};
        tbl[11] = '{"w8 u 255/1",       1, 32'hFF,         32'h01,         0, 32'hFF,         32'h00,         0, 8};
        tbl[12] = '{"w8 s -128/3",      1, 32'h80,         32'h03,         1, 32'hD6,         32'hFE,         0, 8};
        tbl[13] = '{"w8 s -128/-1",     1, 32'h80,         32'hFF,         1, 32'h80,         32'h00,         0, 8};
        tbl[14] = '{"w8 u 200/16",      1, 32'hC8,         32'h10,         0, 32'h0C,         32'h08,         0, 8};
        tbl[15] = '{"w8 s 100/-7",      1, 32'h64,         32'hF9,         1, 32'hF2,         32'h02,         0, 8};

        rst = 1'b1; out_ready = 1'b1;
        iv32 = 1'b0; a32 = '0; b32 = '0; is32 = 1'b0;
        iv8  = 1'b0; a8  = '0; b8  = '0; is8  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready",    {31'b0, ir32}, 32'd1);
        check("reset out_valid",   {31'b0, ov32}, 32'd0);
        check("reset quotient",    q32, 32'd0);
        check("reset remainder",   r32, 32'd0);
        check("reset div_by_zero", {31'b0, dz32}, 32'd0);
        check("reset out_valid w8", {31'b0, ov8}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven vectors with out_ready held high.
        for (int i = 0; i < 16; i++) begin
            run_op(tbl[i].w8, tbl[i].a, tbl[i].b, tbl[i].s, lat, q, r, dz);
            $display("vec %s: q=0x%08h r=0x%08h dz=%0d lat=%0d", tbl[i].name, q, r, dz, lat);
            check({tbl[i].name, " quotient"},    q, tbl[i].q);
            check({tbl[i].name, " remainder"},   r, tbl[i].r);
            check({tbl[i].name, " div_by_zero"}, {31'b0, dz}, {31'b0, tbl[i].dz});
            check({tbl[i].name, " latency"},     lat, tbl[i].lat);
            @(posedge clk); #1;
            check({tbl[i].name, " out_valid after handoff"},
                  {31'b0, tbl[i].w8 ? ov8 : ov32}, 32'd0);
            check({tbl[i].name, " in_ready after handoff"},
                  {31'b0, tbl[i].w8 ? ir8 : ir32}, 32'd1);
            check({tbl[i].name, " quotient held in IDLE"},
                  tbl[i].w8 ? {24'b0, q8} : q32, tbl[i].q);
        end

        // Backpressure: result held for 10 cycles, a pulsed request is ignored.
        out_ready = 1'b0;
        run_op(0, 32'd100, 32'd7, 0, lat, q, r, dz);
        check("bp quotient", q, 32'd14);
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                a32 = 32'd999; b32 = 32'd3; iv32 = 1'b1;
            end else begin
                iv32 = 1'b0;
            end
            @(posedge clk); #1;
            check("bp out_valid",  {31'b0, ov32}, 32'd1);
            check("bp in_ready",   {31'b0, ir32}, 32'd0);
            check("bp quotient",   q32, 32'd14);
            check("bp remainder",  r32, 32'd2);
        end
        $display("backpressure: held 10 cycles, q=0x%08h r=0x%08h", q32, r32);
        iv32 = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release out_valid", {31'b0, ov32}, 32'd0);
        check("bp release in_ready",  {31'b0, ir32}, 32'd1);
        @(posedge clk); #1;
        check("bp pulse not accepted", {31'b0, ir32}, 32'd1);
        check("bp no stray result",    {31'b0, ov32}, 32'd0);

        // Asynchronous reset five cycles into BUSY.
        a32 = 32'd1000; b32 = 32'd3; is32 = 1'b0; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async rst in_ready",    {31'b0, ir32}, 32'd1);
        check("async rst out_valid",   {31'b0, ov32}, 32'd0);
        check("async rst quotient",    q32, 32'd0);
        check("async rst remainder",   r32, 32'd0);
        check("async rst div_by_zero", {31'b0, dz32}, 32'd0);
        $display("reset mid-busy: in_ready=%0d out_valid=%0d q=0x%08h", ir32, ov32, q32);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(0, 32'd200, 32'd10, 0, lat, q, r, dz);
        $display("after reset 200/10: q=0x%08h r=0x%08h lat=%0d", q, r, lat);
        check("post-rst quotient",  q, 32'd20);
        check("post-rst remainder", r, 32'd0);
        check("post-rst latency",   lat, 32'd32);
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Sequential, parametrised integer divider: a multi-cycle successor to the combinational 32-bit divider, computing one quotient bit per clock by restoring shift-subtract. Adds signed/unsigned mode per operation, divide-by-zero detection, and valid/ready handshakes on both sides. Intended as the divide unit behind the CPU's execute stage, or for any datapath that can tolerate WIDTH-cycle latency in exchange for small area.

## Interface

Parameters:
- WIDTH, 32, operand, quotient and remainder width (≥ 2)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  divider can accept a request
- a  in  WIDTH  dividend
- b  in  WIDTH  divisor
- is_signed  in  1  1: two's-complement operands, 0: unsigned
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- quotient  out  WIDTH  quotient
- remainder  out  WIDTH  remainder
- div_by_zero  out  1  result came from b == 0

## Operation

- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready = 1. When in_valid is high at an edge, latch a, b and is_signed; the request is accepted.
  - b == 0: go to DONE with quotient = all ones, remainder = a, div_by_zero = 1.
  - Otherwise: go to BUSY with step counter = WIDTH.
- Signed mode:
  - Divide magnitudes; record quotient sign = sign(a) XOR sign(b) and remainder sign = sign(a).
  - Negate the results on the transition to DONE.
  - Truncation is toward zero, and the remainder takes the sign of the dividend.
  - Overflow case (most-negative / −1) falls out naturally: quotient = most-negative, remainder = 0. There is no special flag.
- BUSY step:
  - Shift the partial remainder (WIDTH+1 bits) left, bringing in the next dividend MSB.
  - If partial ≥ divisor magnitude, subtract and shift 1 into the quotient; else shift 0.
  - Decrement the counter.
  - After the step with counter = 1, go to DONE.
- DONE: out_valid = 1; quotient, remainder and div_by_zero are stable. On out_valid && out_ready, go to IDLE and deassert out_valid.
- in_ready = 1 only in IDLE. There is no same-cycle accept while in DONE.
- Inputs a, b and is_signed are ignored except at the acceptance edge.
- Unsigned mode: is_signed = 0 treats all WIDTH bits as magnitude.

## Timing

- Reset (asynchronous, any state, including mid-BUSY):
  - State returns to IDLE and any in-flight request is discarded.
  - in_ready = 1; out_valid = 0; quotient = 0; remainder = 0; div_by_zero = 0.
- Latency, acceptance edge to first cycle with out_valid = 1:
  - WIDTH cycles for b ≠ 0.
  - 1 cycle for b == 0.
- Throughput: one result per WIDTH + 2 cycles when out_ready is held at 1 (accept, WIDTH steps, handoff).
- in_ready falls on the edge after acceptance. It rises on the edge where the result is taken.
- Output registers change only on the transition into DONE or on reset. They hold their values through IDLE until the next result, so they are not cleared on handoff.
- Backpressure: DONE may persist indefinitely with out_ready = 0. Outputs stay stable and no new request is accepted.

## Test plan

- Unsigned, WIDTH=32: a=100, b=7, is_signed=0 -> quotient=14, remainder=2, div_by_zero=0. out_valid rises exactly 32 cycles after acceptance.
- Signed: a=−7 (0xFFFFFFF9), b=2 -> quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1). Also a=7, b=−2 -> quotient=−3, remainder=1.
- Divide by zero: a=5, b=0 -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, out_valid one cycle after acceptance. The next normal division then gives div_by_zero=0.
- Signed overflow: a=0x80000000, b=0xFFFFFFFF, is_signed=1 -> quotient=0x80000000, remainder=0. The same operands with is_signed=0 -> quotient=0, remainder=0x80000000.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles in DONE: outputs stable, in_ready=0, a pulsed in_valid is not accepted.
  - Assert rst 5 cycles into BUSY: outputs immediately reset to 0, in_ready=1. A fresh request 200/10 then gives 20 r 0.
- WIDTH=8 instance, unsigned: 255/1 -> quotient=255, remainder=0, latency 8 cycles. Signed −128/3 -> quotient=−42 (0xD6), remainder=−2 (0xFE).
